ctrl_reg_arbiter: RTL and testbench

//  Owns the 32x16 host/FPGA command-status register bank and arbitrates its single

---
 rtl/ctrl_reg_arbiter.sv | 95 +++++++++
 tb/tb_ctrl_reg_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_reg_arbiter.sv
// Command/status register bank with a host-priority write port and
// round-robin arbitration among FPGA status sources.
module ctrl_reg_arbiter #(
  parameter int N_SRC  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter logic [2**ADDR_W-1:0] RO_MASK = 32'h0000_000F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       host_din,
  input  logic                    host_we,
  input  logic                    host_re,
  input  logic [ADDR_W-1:0]       host_addr,
  output logic [DATA_W-1:0]       host_dout,
  output logic                    host_dout_vld,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_gnt,
  output logic                    cmd_vld,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [DATA_W-1:0]       cmd_data,
  output logic                    ro_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  logic              host_acc;
  logic              host_ro;
  logic              src_wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % N_SRC);
  endfunction

  assign host_ro  = RO_MASK[host_addr];
  assign host_acc = host_we & ~host_ro;

  // Circular search for the first requester starting at rr_ptr
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_req[wrap(int'(rr_ptr) + k)]) begin
        found   = 1'b1;
        gnt_idx = wrap(int'(rr_ptr) + k);
      end
    end
  end

  assign src_wr = found & ~host_acc & ~rst;

  always_comb begin
    src_gnt = '0;
    if (src_wr) src_gnt[gnt_idx] = 1'b1;
  end

  assign wr_addr = src_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign wr_data = src_data[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rr_ptr        <= '0;
      host_dout     <= '0;
      host_dout_vld <= 1'b0;
      cmd_vld       <= 1'b0;
      cmd_addr      <= '0;
      cmd_data      <= '0;
      ro_err        <= 1'b0;
    end else begin
      host_dout_vld <= host_re;
      if (host_re) host_dout <= mem[host_addr];
      cmd_vld <= host_acc;
      ro_err  <= host_we & host_ro;
      if (host_acc) begin
        mem[host_addr] <= host_din;
        cmd_addr       <= host_addr;
        cmd_data       <= host_din;
      end else if (src_wr) begin
        mem[wr_addr] <= wr_data;
        rr_ptr <= (gnt_idx == PTR_W'(N_SRC-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_reg_arbiter.sv
// Bench for ctrl_reg_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural register-bank model.
module tb_ctrl_reg_arbiter;

  localparam int N = 4;
  localparam logic [31:0] RO = 32'h0000_000F;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] host_din;
  logic        host_we, host_re;
  logic [4:0]  host_addr;
  logic [15:0] host_dout;
  logic        host_dout_vld;
  logic [N-1:0] src_req;
  logic [N*5-1:0]  src_addr;
  logic [N*16-1:0] src_data;
  logic [N-1:0] src_gnt;
  logic        cmd_vld;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        ro_err;

  logic [4:0]  sa [N];
  logic [15:0] sd [N];

  always_comb begin
    src_addr = '0;
    src_data = '0;
    for (int i = 0; i < N; i++) begin
      src_addr[i*5 +: 5]   = sa[i];
      src_data[i*16 +: 16] = sd[i];
    end
  end

  always #5 clk = ~clk;

  ctrl_reg_arbiter dut (
    .clk(clk), .rst(rst),
    .host_din(host_din), .host_we(host_we), .host_re(host_re),
    .host_addr(host_addr), .host_dout(host_dout),
    .host_dout_vld(host_dout_vld),
    .src_req(src_req), .src_addr(src_addr), .src_data(src_data),
    .src_gnt(src_gnt), .cmd_vld(cmd_vld), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .ro_err(ro_err)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_mem [32];
  int          m_ptr;
  logic [15:0] m_dout;
  logic        m_vld, m_cvld, m_ro;
  logic [4:0]  m_caddr;
  logic [15:0] m_cdata;
  logic [N-1:0] obs_gnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_ptr = 0; m_dout = 0; m_vld = 0; m_cvld = 0; m_ro = 0;
    m_caddr = 0; m_cdata = 0;
  endtask

  // One clock: check grant mid-cycle, then registered outputs after edge
  task automatic tick();
    int g;
    bit acc;
    g = -1;
    acc = host_we && !RO[host_addr];
    if (!rst && !acc)
      for (int k = 0; k < N; k++)
        if (g < 0 && src_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    @(negedge clk);
    obs_gnt = src_gnt;
    chk("gnt", 32'(src_gnt), (g < 0) ? 32'd0 : 32'(1 << g));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_vld = host_re;
      if (host_re) m_dout = 16'(m_mem[host_addr]);
      m_ro = host_we && RO[host_addr];
      m_cvld = acc;
      if (acc) begin
        m_caddr = host_addr; m_cdata = host_din;
        m_mem[host_addr] = host_din;
      end else if (g >= 0) begin
        m_mem[sa[g]] = sd[g];
        m_ptr = (g + 1) % N;
      end
    end
    #1;
    chk("m_dout", 32'(host_dout), 32'(m_dout));
    chk("m_vld", 32'(host_dout_vld), 32'(m_vld));
    chk("m_cmd_vld", 32'(cmd_vld), 32'(m_cvld));
    chk("m_cmd_addr", 32'(cmd_addr), 32'(m_caddr));
    chk("m_cmd_data", 32'(cmd_data), 32'(m_cdata));
    chk("m_ro_err", 32'(ro_err), 32'(m_ro));
  endtask

  task automatic host(input bit we, input bit re, input logic [4:0] a,
                      input logic [15:0] d);
    host_we = we; host_re = re; host_addr = a; host_din = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host(0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit we; bit re; logic [4:0] addr; logic [15:0] din;
    bit vld; logic [15:0] dout;
    bit cvld; logic [4:0] caddr; logic [15:0] cdata; bit ro;
  } vec_t;

  vec_t tbl [10];
  int   wait_cnt [N];

  initial begin
    tbl[0] = '{1, 0, 5'd5,  16'hBEEF, 0, 16'h0000, 1, 5'd5,  16'hBEEF, 0};
    tbl[1] = '{0, 1, 5'd5,  16'h0000, 1, 16'hBEEF, 0, 5'd5,  16'hBEEF, 0};
    tbl[2] = '{1, 0, 5'd2,  16'h1234, 0, 16'hBEEF, 0, 5'd5,  16'hBEEF, 1};
    tbl[3] = '{0, 1, 5'd2,  16'h0000, 1, 16'h0000, 0, 5'd5,  16'hBEEF, 0};
    tbl[4] = '{1, 1, 5'd9,  16'h00AA, 1, 16'h0000, 1, 5'd9,  16'h00AA, 0};
    tbl[5] = '{0, 1, 5'd9,  16'h0000, 1, 16'h00AA, 0, 5'd9,  16'h00AA, 0};
    tbl[6] = '{1, 0, 5'd31, 16'hFFFF, 0, 16'h00AA, 1, 5'd31, 16'hFFFF, 0};
    tbl[7] = '{0, 1, 5'd31, 16'h0000, 1, 16'hFFFF, 0, 5'd31, 16'hFFFF, 0};
    tbl[8] = '{1, 0, 5'd0,  16'h5555, 0, 16'hFFFF, 0, 5'd31, 16'hFFFF, 1};
    tbl[9] = '{0, 1, 5'd0,  16'h0000, 1, 16'h0000, 0, 5'd31, 16'hFFFF, 0};

    src_req = '0;
    for (int i = 0; i < N; i++) begin sa[i] = '0; sd[i] = '0; end
    rst = 1'b1;
    host(0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("rst_cmd_vld", 32'(cmd_vld), 0);
    chk("rst_ro_err", 32'(ro_err), 0);

    // every register reads zero after reset
    for (int a = 0; a < 32; a++) begin
      host(0, 1, 5'(a), 0);
      tick();
      chk("rst_read_vld", 32'(host_dout_vld), 1);
      chk("rst_read", 32'(host_dout), 0);
    end
    host(0, 0, 0, 0);
    tick();
    chk("vld_drop", 32'(host_dout_vld), 0);

    for (int i = 0; i < 10; i++) begin
      host(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din);
      tick();
      chk($sformatf("tbl%0d_vld", i), 32'(host_dout_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_dout", i), 32'(host_dout), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d_cvld", i), 32'(cmd_vld), 32'(tbl[i].cvld));
      chk($sformatf("tbl%0d_caddr", i), 32'(cmd_addr), 32'(tbl[i].caddr));
      chk($sformatf("tbl%0d_cdata", i), 32'(cmd_data), 32'(tbl[i].cdata));
      chk($sformatf("tbl%0d_ro", i), 32'(ro_err), 32'(tbl[i].ro));
    end

    // round robin, all four held
    do_reset();
    for (int i = 0; i < N; i++) begin
      sa[i] = 5'(16 + i); sd[i] = 16'(16'hA0 + i);
    end
    src_req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_gnt", 32'(obs_gnt), 32'(1 << (c % N)));
    end
    src_req = '0;
    for (int i = 0; i < N; i++) begin
      host(0, 1, 5'(16 + i), 0);
      tick();
      chk("rr_data", 32'(host_dout), 32'(16'hA0 + i));
    end

    // host priority over source 1
    src_req = 4'b0010; sa[1] = 5'd20; sd[1] = 16'h0101;
    host(1, 0, 5'd8, 16'h0808);
    tick();
    chk("prio_gnt0", 32'(obs_gnt), 0);
    host(0, 0, 0, 0);
    tick();
    chk("prio_gnt1", 32'(obs_gnt), 32'h2);
    src_req = '0;

    // read-before-write collision with a source write
    src_req = 4'b0001; sa[0] = 5'd1; sd[0] = 16'h0007;
    host(0, 1, 5'd1, 0);
    tick();
    chk("col_gnt", 32'(obs_gnt), 1);
    chk("col_old", 32'(host_dout), 0);
    src_req = '0;
    tick();
    chk("col_new", 32'(host_dout), 32'h0007);

    // randomized traffic with mid-run resets
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      bit acc;
      rst = ($urandom_range(0, 199) == 0);
      host($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           5'($urandom), 16'($urandom));
      acc = host_we && !RO[host_addr];
      tick();
      for (int i = 0; i < N; i++) begin
        if (src_req[i] && !rst && !acc) wait_cnt[i]++;
        if (obs_gnt[i]) begin
          chk("starve", 32'(wait_cnt[i] <= N), 1);
          wait_cnt[i] = 0;
          src_req[i] = $urandom_range(0, 1) == 1;
          sa[i] = 5'($urandom); sd[i] = 16'($urandom);
        end else if (!src_req[i] && $urandom_range(0, 2) == 0) begin
          src_req[i] = 1'b1;
          sa[i] = 5'($urandom); sd[i] = 16'($urandom);
        end
        if (rst) wait_cnt[i] = 0;
      end
    end
    rst = 1'b0;
    src_req = '0;
    host(0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
